// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and fill-counter width helper for the pattern detector
//   SEQ_LEN_DEFAULT  default pattern length
//   CNT_W            width of the optional match counter
//   fill_w(n)        bits needed to count 0..n received samples
package seq_det_pkg;
  localparam int SEQ_LEN_DEFAULT = 6;
  localparam int CNT_W = 16;
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial bit source to detector link
//   x    serial data bit, one per clock
//   seq  target pattern, seq[N-1] received first
//   z    registered match pulse back to the source side
//   master = bit source / consumer of z, slave = detector
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int N = SEQ_LEN_DEFAULT
);
  logic x;
  logic [N-1:0] seq;
  logic z;
  modport master(output x, output seq, input z);
  modport slave(input x, input seq, output z);
endinterface

// File: rtl/seq_det_hist.sv
// seq_det_hist: serial history shift register with saturating fill counter
//   clk   clock, rst async active-low reset
//   x     serial input bit
//   hist  last N-1 received bits, oldest at MSB
//   full  high once at least N-1 bits are held, so the live bit completes a window
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int N = SEQ_LEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         x,
  output logic [N-2:0] hist,
  output logic         full
);
  localparam int W = fill_w(N);
  logic [W-1:0] fill;
  // The oldest of N bits is never compared (the live x fills the window's LSB),
  // so only N-1 bits of history are stored.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= {hist[N-3:0], x};
      fill <= (fill == W'(N)) ? fill : fill + 1'b1;
    end
  assign full = fill >= W'(N - 1);
endmodule

// File: rtl/seq_det.sv
// seq_det: programmable serial pattern detector with overlapping matches
//   clk        clock, all updates on posedge
//   rst        asynchronous active-low reset
//   bus        seq_det_if slave: x and seq in, registered match pulse z out
//   match_cnt  wrapping match counter, only with SEQ_DET_MATCH_COUNT_EN defined
module seq_det
  import seq_det_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_if.slave         bus
`ifdef SEQ_DET_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);
  logic [SEQ_LEN-2:0] hist;
  logic full;
  logic hit;
  seq_det_hist #(.N(SEQ_LEN)) u_hist (
    .clk (clk),
    .rst (rst),
    .x   (bus.x),
    .hist(hist),
    .full(full)
  );
  // seq is compared live, so a pattern change takes effect on the next edge
  assign hit = full && ({hist, bus.x} == bus.seq);
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.z <= 1'b0;
    else bus.z <= hit;
`ifdef SEQ_DET_MATCH_COUNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) match_cnt <= '0;
    else if (hit) match_cnt <= match_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_seq_det.sv
// tb_seq_det: directed self-checking bench for seq_det
module tb_seq_det;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  seq_det_if #(.N(6)) bus ();
`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [15:0] match_cnt;
`endif
  seq_det #(.SEQ_LEN(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic xv, input logic ez, input string tag);
    bus.x = xv;
    @(posedge clk);
    #1;
    chk(tag, {15'd0, bus.z}, {15'd0, ez});
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.x = 1'b1;
    #1;
    chk("z_async_reset", {15'd0, bus.z}, 16'd0);
    @(posedge clk);
    #1;
    chk("z_hold_in_reset", {15'd0, bus.z}, 16'd0);
`ifdef SEQ_DET_MATCH_COUNT_EN
    chk("cnt_reset", match_cnt, 16'd0);
`endif
    rst = 1'b1;
  endtask
  initial begin
    bus.x = 1'b1;
    bus.seq = 6'b101010;
    #2;
    chk("z_reset", {15'd0, bus.z}, 16'd0);
    rst = 1'b1;
    step(1'b1, 1'b0, "s1_b1");
    step(1'b0, 1'b0, "s1_b2");
    step(1'b1, 1'b0, "s1_b3");
    step(1'b0, 1'b0, "s1_b4");
    step(1'b1, 1'b0, "s1_b5");
    step(1'b0, 1'b1, "s1_match");
    step(1'b1, 1'b0, "s1_drop");
    step(1'b0, 1'b1, "s2_overlap");
`ifdef SEQ_DET_MATCH_COUNT_EN
    chk("s2_cnt", match_cnt, 16'd2);
`endif
    do_reset();
    bus.seq = 6'b000000;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "s3_guard");
    step(1'b0, 1'b1, "s3_first");
    step(1'b0, 1'b1, "s3_hold1");
    step(1'b0, 1'b1, "s3_hold2");
`ifdef SEQ_DET_MATCH_COUNT_EN
    chk("s3_cnt", match_cnt, 16'd3);
`endif
    do_reset();
    bus.seq = 6'b101010;
    step(1'b1, 1'b0, "s4_pre1");
    step(1'b0, 1'b0, "s4_pre2");
    step(1'b1, 1'b0, "s4_pre3");
    step(1'b0, 1'b0, "s4_pre4");
    step(1'b1, 1'b0, "s4_pre5");
    do_reset();
    step(1'b0, 1'b0, "s4_no_pulse");
    step(1'b1, 1'b0, "s4_b1");
    step(1'b0, 1'b0, "s4_b2");
    step(1'b1, 1'b0, "s4_b3");
    step(1'b0, 1'b0, "s4_b4");
    step(1'b1, 1'b0, "s4_b5");
    step(1'b0, 1'b1, "s4_match");
    step(1'b1, 1'b0, "s5_h1");
    step(1'b1, 1'b0, "s5_h2");
    step(1'b1, 1'b0, "s5_h3");
    step(1'b0, 1'b0, "s5_h4");
    step(1'b0, 1'b0, "s5_h5");
    step(1'b0, 1'b0, "s5_h6");
    bus.seq = 6'b110001;
    step(1'b1, 1'b1, "s5_seq_change");
    step(1'b0, 1'b0, "s5_after");
`ifdef SEQ_DET_MATCH_COUNT_EN
    do_reset();
    bus.seq = 6'b000000;
    bus.x = 1'b0;
    for (int i = 0; i < 5 + 65536; i++) @(posedge clk);
    #1;
    chk("s6_wrap", match_cnt, 16'd0);
    chk("s6_z", {15'd0, bus.z}, 16'd1);
    @(posedge clk);
    #1;
    chk("s6_after_wrap", match_cnt, 16'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
